// File: rtl/alu_exec_unit.sv
// Multi-cycle execute/writeback unit: IDLE -> READ -> EXEC -> WB, driving the
// register file read ports, computing an ALU result and writing it back.
module alu_exec_unit #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [15:0]   instr,
  input  logic          instr_valid,
  output logic          instr_ready,
  output logic [AW-1:0] RA1,
  output logic [AW-1:0] RA2,
  input  logic [DW-1:0] RD1,
  input  logic [DW-1:0] RD2,
  output logic [AW-1:0] WA,
  output logic [DW-1:0] ALUResult,
  output logic          write_enable,
  output logic          flag_z,
  output logic          flag_c,
  output logic          done
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  state_t        state, state_nx;
  logic [15:0]   instr_q;
  logic [DW-1:0] opa, opb, result_q;
  logic          nz_q, nc_q, upd_q;

  logic [3:0]    op;
  logic [AW-1:0] rd, rs1, rs2;
  logic [DW-1:0] imm;

  assign op  = instr_q[15:12];
  assign rd  = AW'(instr_q[11:8]);
  assign rs1 = AW'(instr_q[7:4]);
  assign rs2 = AW'(instr_q[3:0]);
  assign imm = DW'(instr_q[7:0]);

  // ALU: non-writing opcodes keep the previous result and carry
  logic [DW-1:0] alu_res;
  logic          alu_c, alu_upd;

  always_comb begin
    alu_res = result_q;
    alu_c   = flag_c;
    alu_upd = 1'b1;
    unique case (op)
      4'd1: {alu_c, alu_res} = {1'b0, opa} + {1'b0, opb};
      4'd2: begin alu_res = opa - opb; alu_c = (opa < opb); end
      4'd3: begin alu_res = opa & opb; alu_c = 1'b0; end
      4'd4: begin alu_res = opa | opb; alu_c = 1'b0; end
      4'd5: begin alu_res = opa ^ opb; alu_c = 1'b0; end
      4'd6: begin
        alu_res = (32'(opb[3:0]) >= DW) ? '0 : opa << opb[3:0];
        alu_c   = 1'b0;
      end
      4'd7: begin
        alu_res = (32'(opb[3:0]) >= DW) ? '0 : opa >> opb[3:0];
        alu_c   = 1'b0;
      end
      4'd8: alu_res = imm;
      4'd9: alu_res = opa;
      default: alu_upd = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      instr_q  <= '0;
      opa      <= '0;
      opb      <= '0;
      result_q <= '0;
      nz_q     <= 1'b0;
      nc_q     <= 1'b0;
      upd_q    <= 1'b0;
      flag_z   <= 1'b0;
      flag_c   <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (instr_valid) instr_q <= instr;
        READ: begin
          opa <= RD1;
          opb <= RD2;
        end
        EXEC: begin
          result_q <= alu_res;
          nz_q     <= (alu_res == '0);
          nc_q     <= alu_c;
          upd_q    <= alu_upd;
        end
        WB: if (upd_q) begin
          flag_z <= nz_q;
          flag_c <= nc_q;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (instr_valid) state_nx = READ;
      READ: state_nx = EXEC;
      EXEC: state_nx = WB;
      WB:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    instr_ready  = (state == IDLE);
    RA1          = '0;
    RA2          = '0;
    WA           = '0;
    write_enable = 1'b0;
    done         = 1'b0;
    if (state == READ) begin
      RA1 = rs1;
      RA2 = rs2;
    end
    if (state == WB) begin
      WA           = rd;
      write_enable = upd_q && (rd != '0);
      done         = 1'b1;
    end
  end

  assign ALUResult = result_q;

endmodule
